// File: rtl/point_nd_store.sv
// Serially loaded N-dimensional point register with length check and serial replay.
// Optional L1-norm output is enabled by defining POINT_L1_NORM_EN.
module point_nd_store #(
  parameter int DIMENSION = 2,
  parameter int COORD_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic signed [COORD_W-1:0]     wr_data,
  input  logic                          wr_last,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic signed [COORD_W-1:0]     rd_data,
  output logic [3:0]                    rd_index,
  output logic                          rd_last,
  output logic [DIMENSION*COORD_W-1:0]  coords,
  output logic                          pt_valid,
  output logic                          len_err
`ifdef POINT_L1_NORM_EN
  ,
  output logic [COORD_W+3:0]            l1_norm,
  output logic                          l1_valid
`endif
);

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] DIM_I     = IDX_W'(DIMENSION);
  localparam logic [IDX_W-1:0] LAST_I    = IDX_W'(DIMENSION - 1);
  localparam logic [3:0]       RD_LAST_I = 4'(DIMENSION - 1);

  if (DIMENSION < 1 || DIMENSION > 16) begin : g_dim_chk
    $error("point_nd_store: DIMENSION must be in 1..16");
  end

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic signed [COORD_W-1:0] coord_q [DIMENSION];
  logic signed [COORD_W-1:0] coord_d [DIMENSION];
  logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic                      ovf_q, ovf_d;
  logic                      pt_valid_q, pt_valid_d;
  logic                      len_err_q, len_err_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      rd_last_q, rd_last_d;
  logic [3:0]                rd_index_q, rd_index_d;
  logic signed [COORD_W-1:0] rd_data_q, rd_data_d;
  logic [3:0]                rd_nxt;
  logic                      wr_fire;

  always_comb begin
    state_d    = state_q;
    coord_d    = coord_q;
    wr_idx_d   = wr_idx_q;
    ovf_d      = ovf_q;
    pt_valid_d = pt_valid_q;
    len_err_d  = len_err_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_index_d = rd_index_q;
    rd_data_d  = rd_data_q;
    rd_nxt     = rd_index_q + 4'd1;
    wr_fire    = wr_valid && (state_q == IDLE);

    if (wr_fire) begin
      // index 0 with no overflow pending can only be the first beat of a point
      if (wr_idx_q == '0 && !ovf_q) begin
        pt_valid_d = 1'b0;
        len_err_d  = 1'b0;
      end
      if (wr_idx_q < DIM_I) begin
        for (int i = 0; i < DIMENSION; i++) begin
          if (wr_idx_q == IDX_W'(i)) coord_d[i] = wr_data;
        end
        wr_idx_d = wr_idx_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
      if (wr_last) begin
        wr_idx_d = '0;
        ovf_d    = 1'b0;
        if (!ovf_q && wr_idx_q == LAST_I) begin
          pt_valid_d = 1'b1;
          len_err_d  = 1'b0;
        end else begin
          pt_valid_d = 1'b0;
          len_err_d  = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_index_d = '0;
        rd_data_d  = '0;
        // a coincident accepted write takes priority and the request is lost
        if (rd_req && pt_valid_q && !wr_fire) begin
          state_d    = READ;
          rd_valid_d = 1'b1;
          rd_index_d = '0;
          rd_data_d  = coord_q[0];
          rd_last_d  = (DIMENSION == 1);
        end
      end
      READ: begin
        if (rd_last_q) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          rd_index_d = '0;
          rd_data_d  = '0;
        end else begin
          rd_index_d = rd_nxt;
          rd_last_d  = (rd_nxt == RD_LAST_I);
          for (int i = 0; i < DIMENSION; i++) begin
            if (rd_nxt == 4'(i)) rd_data_d = coord_q[i];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < DIMENSION; i++) coord_q[i] <= '0;
      wr_idx_q   <= '0;
      ovf_q      <= 1'b0;
      pt_valid_q <= 1'b0;
      len_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_index_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      coord_q    <= coord_d;
      wr_idx_q   <= wr_idx_d;
      ovf_q      <= ovf_d;
      pt_valid_q <= pt_valid_d;
      len_err_q  <= len_err_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_index_q <= rd_index_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    coords = '0;
    for (int i = 0; i < DIMENSION; i++) coords[i*COORD_W +: COORD_W] = coord_q[i];
  end

  assign wr_ready = (state_q == IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_index = rd_index_q;
  assign rd_last  = rd_last_q;
  assign pt_valid = pt_valid_q;
  assign len_err  = len_err_q;

`ifdef POINT_L1_NORM_EN
  // magnitude is taken one bit wider so the most-negative value cannot overflow
  function automatic logic [COORD_W:0] abs_ext(input logic signed [COORD_W-1:0] v);
    logic signed [COORD_W:0] e;
    e = {v[COORD_W-1], v};
    return v[COORD_W-1] ? (COORD_W+1)'(-e) : (COORD_W+1)'(e);
  endfunction

  logic [COORD_W+3:0] l1_sum;
  logic [COORD_W+3:0] l1_norm_q, l1_norm_d;
  logic               l1_valid_q, l1_valid_d;
  logic               l1_pend_q, l1_pend_d;

  always_comb begin
    l1_sum = '0;
    for (int i = 0; i < DIMENSION; i++) l1_sum = l1_sum + (COORD_W+4)'(abs_ext(coord_q[i]));
    l1_pend_d  = wr_fire && wr_last && !ovf_q && (wr_idx_q == LAST_I);
    l1_norm_d  = l1_norm_q;
    l1_valid_d = l1_valid_q;
    if (l1_pend_q) begin
      l1_norm_d  = l1_sum;
      l1_valid_d = 1'b1;
    end
    if (!pt_valid_d || wr_fire) begin
      l1_norm_d  = '0;
      l1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l1_norm_q  <= '0;
      l1_valid_q <= 1'b0;
      l1_pend_q  <= 1'b0;
    end else begin
      l1_norm_q  <= l1_norm_d;
      l1_valid_q <= l1_valid_d;
      l1_pend_q  <= l1_pend_d;
    end
  end

  assign l1_norm  = l1_norm_q;
  assign l1_valid = l1_valid_q;
`endif

endmodule

// File: tb/tb_point_nd_store.sv
// Scoreboard bench for point_nd_store: a DIMENSION=3 and a DIMENSION=1 instance.
// Define POINT_L1_NORM_EN for both bench and RTL to exercise the L1-norm outputs.
module tb_point_nd_store;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DIMENSION=3 instance signals
  logic        wv, wl, rq;
  logic [31:0] wd;
  logic        wr_ready, rd_valid, rd_last, pt_valid, len_err;
  logic [31:0] rd_data;
  logic [3:0]  rd_index;
  logic [95:0] coords;
`ifdef POINT_L1_NORM_EN
  logic [35:0] l1_norm;
  logic        l1_valid;
`endif

  // DIMENSION=1 instance signals
  logic        wv1, wl1, rq1;
  logic [31:0] wd1;
  logic        wr_ready1, rd_valid1, rd_last1, pt_valid1, len_err1;
  logic [31:0] rd_data1;
  logic [3:0]  rd_index1;
  logic [31:0] coords1;
`ifdef POINT_L1_NORM_EN
  logic [35:0] l1_norm1;
  logic        l1_valid1;
`endif

  point_nd_store #(.DIMENSION(3), .COORD_W(32)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv), .wr_ready(wr_ready), .wr_data(wd),
    .wr_last(wl), .rd_req(rq), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_index(rd_index), .rd_last(rd_last), .coords(coords), .pt_valid(pt_valid),
    .len_err(len_err)
`ifdef POINT_L1_NORM_EN
    , .l1_norm(l1_norm), .l1_valid(l1_valid)
`endif
  );

  point_nd_store #(.DIMENSION(1), .COORD_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv1), .wr_ready(wr_ready1), .wr_data(wd1),
    .wr_last(wl1), .rd_req(rq1), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .rd_index(rd_index1), .rd_last(rd_last1), .coords(coords1), .pt_valid(pt_valid1),
    .len_err(len_err1)
`ifdef POINT_L1_NORM_EN
    , .l1_norm(l1_norm1), .l1_valid(l1_valid1)
`endif
  );

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t q3[$];
  beat_t q1[$];
  beat_t b3, b1;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_pt3(input string tag, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2);
    chk({tag, "_c0"}, 64'(coords[31:0]), 64'(c0));
    chk({tag, "_c1"}, 64'(coords[63:32]), 64'(c1));
    chk({tag, "_c2"}, 64'(coords[95:64]), 64'(c2));
  endtask

  task automatic push3(input logic [3:0] i, input logic [31:0] d, input logic l);
    beat_t b;
    b.idx = i; b.data = d; b.last = l;
    q3.push_back(b);
  endtask

  task automatic beat3(input logic [31:0] d, input logic l);
    wv = 1'b1; wd = d; wl = l;
    @(posedge clk); #1;
    wv = 1'b0; wl = 1'b0;
  endtask

  task automatic beat1(input logic [31:0] d, input logic l);
    wv1 = 1'b1; wd1 = d; wl1 = l;
    @(posedge clk); #1;
    wv1 = 1'b0; wl1 = 1'b0;
  endtask

  task automatic req3(input string tag);
    rq = 1'b1;
    @(posedge clk); #1;
    rq = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (q3.size() == 0) break;
    end
    chk({tag, "_drained"}, 64'(q3.size()), 64'd0);
    chk({tag, "_idle_after"}, 64'(rd_valid), 64'd0);
  endtask

  task automatic req1(input string tag);
    rq1 = 1'b1;
    @(posedge clk); #1;
    rq1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (q1.size() == 0) break;
    end
    chk({tag, "_drained"}, 64'(q1.size()), 64'd0);
    chk({tag, "_idle_after"}, 64'(rd_valid1), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      chk("rd3_wr_ready", 64'(wr_ready), 64'd0);
      if (q3.size() == 0) begin
        chk("rd3_unexpected_beat", 64'd1, 64'd0);
      end else begin
        b3 = q3.pop_front();
        chk("rd3_index", 64'(rd_index), 64'(b3.idx));
        chk("rd3_data", 64'(rd_data), 64'(b3.data));
        chk("rd3_last", 64'(rd_last), 64'(b3.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid1) begin
      if (q1.size() == 0) begin
        chk("rd1_unexpected_beat", 64'd1, 64'd0);
      end else begin
        b1 = q1.pop_front();
        chk("rd1_index", 64'(rd_index1), 64'(b1.idx));
        chk("rd1_data", 64'(rd_data1), 64'(b1.data));
        chk("rd1_last", 64'(rd_last1), 64'(b1.last));
      end
    end
  end

  initial begin
    wv = 0; wl = 0; rq = 0; wd = '0;
    wv1 = 0; wl1 = 0; rq1 = 0; wd1 = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pt_valid", 64'(pt_valid), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_index", 64'(rd_index), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    exp_pt3("rst", 32'd0, 32'd0, 32'd0);
    chk("rst1_coords", 64'(coords1), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // exact-length load and replay
    beat3(32'd3, 1'b0);
    beat3(32'd4, 1'b0);
    beat3(32'd5, 1'b1);
    chk("load_pt_valid", 64'(pt_valid), 64'd1);
    chk("load_len_err", 64'(len_err), 64'd0);
    exp_pt3("load", 32'd3, 32'd4, 32'd5);
    push3(4'd0, 32'd3, 1'b0);
    push3(4'd1, 32'd4, 1'b0);
    push3(4'd2, 32'd5, 1'b1);
    req3("read_a");

    // overlong load: extra beat discarded, error flagged, no replay
    beat3(32'd13, 1'b0);
    chk("long_first_clears_pt", 64'(pt_valid), 64'd0);
    beat3(32'd14, 1'b0);
    beat3(32'd15, 1'b0);
    beat3(32'd16, 1'b1);
    chk("long_len_err", 64'(len_err), 64'd1);
    chk("long_pt_valid", 64'(pt_valid), 64'd0);
    exp_pt3("long", 32'd13, 32'd14, 32'd15);
    req3("read_invalid");

    // load after overflow starts cleanly at index 0
    beat3(32'd7, 1'b0);
    chk("reload_clears_err", 64'(len_err), 64'd0);
    beat3(32'd8, 1'b0);
    beat3(32'd9, 1'b1);
    chk("reload_pt_valid", 64'(pt_valid), 64'd1);
    exp_pt3("reload", 32'd7, 32'd8, 32'd9);

    // short load keeps unwritten coordinates
    beat3(32'hFFFF_FFFD, 1'b1);
    chk("short_len_err", 64'(len_err), 64'd1);
    chk("short_pt_valid", 64'(pt_valid), 64'd0);
    exp_pt3("short", 32'hFFFF_FFFD, 32'd8, 32'd9);

    // write coinciding with rd_req wins; request dropped
    beat3(32'd10, 1'b0);
    beat3(32'd11, 1'b0);
    beat3(32'd12, 1'b1);
    chk("pre_coll_pt_valid", 64'(pt_valid), 64'd1);
    rq = 1'b1;
    beat3(32'd20, 1'b0);
    rq = 1'b0;
    chk("coll_rd_valid", 64'(rd_valid), 64'd0);
    chk("coll_pt_cleared", 64'(pt_valid), 64'd0);
    beat3(32'd21, 1'b0);
    beat3(32'd22, 1'b1);
    exp_pt3("coll", 32'd20, 32'd21, 32'd22);

    // DIMENSION=1: single beat is both first and last
    beat1(32'd6, 1'b1);
    chk("d1_pt_valid", 64'(pt_valid1), 64'd1);
    chk("d1_len_err", 64'(len_err1), 64'd0);
    chk("d1_coords", 64'(coords1), 64'd6);
    q1.push_back('{idx: 4'd0, data: 32'd6, last: 1'b1});
    req1("d1_read");
    beat1(32'd1, 1'b0);
    beat1(32'd2, 1'b1);
    chk("d1_long_err", 64'(len_err1), 64'd1);
    chk("d1_long_pt", 64'(pt_valid1), 64'd0);
    chk("d1_long_coords", 64'(coords1), 64'd1);

    // reset during a replay aborts it at once
    rq = 1'b1;
    @(posedge clk); #1;
    rq = 1'b0;
    chk("mid_rd_valid", 64'(rd_valid), 64'd1);
    chk("mid_rd_data", 64'(rd_data), 64'd20);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rd_valid", 64'(rd_valid), 64'd0);
    chk("abort_rd_data", 64'(rd_data), 64'd0);
    chk("abort_rd_index", 64'(rd_index), 64'd0);
    chk("abort_pt_valid", 64'(pt_valid), 64'd0);
    chk("abort_wr_ready", 64'(wr_ready), 64'd1);
    exp_pt3("abort", 32'd0, 32'd0, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef POINT_L1_NORM_EN
    beat3(32'hFFFF_FFFD, 1'b0);
    beat3(32'd4, 1'b0);
    beat3(32'hFFFF_FFFB, 1'b1);
    chk("l1_pt_valid", 64'(pt_valid), 64'd1);
    chk("l1_not_yet", 64'(l1_valid), 64'd0);
    @(posedge clk); #1;
    chk("l1_valid", 64'(l1_valid), 64'd1);
    chk("l1_norm", 64'(l1_norm), 64'd12);
    beat3(32'd1, 1'b0);
    chk("l1_clr_valid", 64'(l1_valid), 64'd0);
    chk("l1_clr_norm", 64'(l1_norm), 64'd0);
    beat3(32'h8000_0000, 1'b0);
    beat3(32'h8000_0000, 1'b1);
    beat3(32'h8000_0000, 1'b0);
    beat3(32'h8000_0000, 1'b0);
    beat3(32'h8000_0000, 1'b1);
    @(posedge clk); #1;
    chk("l1_minneg_valid", 64'(l1_valid), 64'd1);
    chk("l1_minneg_norm", 64'(l1_norm), 64'h1_8000_0000);
`endif

    chk("q3_empty_end", 64'(q3.size()), 64'd0);
    chk("q1_empty_end", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/point_nd_store.md
Name: point_nd_store

Overview:
- Register file holding one N-dimensional point of signed integer coordinates.
- Coordinates are loaded as a serial stream with an end-of-point marker. The block checks the loaded length against DIMENSION and can replay the stored point as a serial readout stream.
- Sits between a coordinate producer (graph data source) and downstream graphing/display logic.

Parameters:
- DIMENSION, 2, number of coordinates per point; legal range 1..16; value 0 is an elaboration error.
- COORD_W, 32, coordinate width in bits, two's-complement signed.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  coordinate beat valid.
- wr_ready  out  1  block can accept a beat.
- wr_data  in  COORD_W  coordinate value.
- wr_last  in  1  marks final beat of a point.
- rd_req  in  1  single-cycle request to stream the stored point.
- rd_valid  out  1  readout beat valid.
- rd_data  out  COORD_W  readout coordinate.
- rd_index  out  4  coordinate index of the current readout beat.
- rd_last  out  1  final readout beat.
- coords  out  DIMENSION*COORD_W  all coordinates in parallel; coordinate i occupies bits [i*COORD_W +: COORD_W].
- pt_valid  out  1  stored point is complete and length-correct.
- len_err  out  1  last load had the wrong beat count.

Behaviour:
- Reset (async assert, sync release):
  - coords = 0, pt_valid = 0, len_err = 0.
  - rd_valid = 0, rd_last = 0, rd_index = 0, rd_data = 0.
  - Write index = 0, state = IDLE.
- States: IDLE and READ.
- wr_ready = 1 in IDLE and 0 in READ. A beat is accepted when wr_valid && wr_ready.
- Load rules:
  - Accepted beat with write index < DIMENSION: store wr_data into coord[index] on that edge; index increments (saturating at DIMENSION).
  - Accepted beat with index >= DIMENSION (overflow): data discarded and an internal overflow flag is set.
  - First accepted beat of a new point clears pt_valid and len_err.
  - Accepted beat with wr_last: index returns to 0 and the overflow flag clears. If exactly DIMENSION beats were received (this one included): pt_valid = 1 and len_err = 0 on the next cycle. Otherwise pt_valid = 0 and len_err = 1.
  - Short load: unwritten coordinates keep their previous values.
  - Single-beat point (DIMENSION = 1) works: first and last beat in the same cycle.
- Read rules:
  - rd_req in IDLE while pt_valid = 1 moves to READ.
  - Beat k (k = 0..DIMENSION-1) appears k+1 cycles after the rd_req cycle, one beat per cycle, no back-pressure.
  - Each beat drives rd_valid = 1, rd_index = k, rd_data = coord[k]. rd_last = 1 on k = DIMENSION-1, then the block returns to IDLE.
  - rd_req is ignored when pt_valid = 0 or when already in READ.
  - If rd_req and an accepted write coincide in IDLE, the write wins and rd_req is dropped.
- coords is the live register contents at all times.
- Reset mid-READ aborts the stream immediately: rd_valid drops asynchronously. Reset mid-load discards the partial point.

Optional Feature:
- Macro POINT_L1_NORM_EN.
- Defined:
  - Extra outputs l1_norm (unsigned, COORD_W+4 bits) and l1_valid.
  - l1_norm is the registered sum of |coord[i]| over all coordinates, updated one cycle after pt_valid rises. l1_valid rises with that update and clears whenever pt_valid clears.
  - |most-negative value| is computed in COORD_W+1 bits, so there is no overflow.
- Not defined: the ports and the adder logic are absent; all other behaviour is identical.

Test Plan:
- DIMENSION=3: load 3, 4, 5 with wr_last on 5 -> pt_valid=1, len_err=0, coords = {5,4,3} (coord0 = 3, coord1 = 4, coord2 = 5).
- Same point, pulse rd_req -> three consecutive beats (0,3), (1,4), (2,5); rd_last only on index 2; wr_ready=0 during the stream.
- DIMENSION=2: load 3, 4, 5, last on 5 -> len_err=1, pt_valid=0, coords hold 3, 4; a following rd_req produces no rd_valid.
- DIMENSION=2: after a valid 7, 8 load, send single beat 3 with wr_last -> len_err=1, pt_valid=0, coord0=3, coord1=8.
- DIMENSION=1: beat 6 with wr_last -> pt_valid=1; rd_req -> one beat (index 0, data 6, rd_last=1). Assert rst_n low during a DIMENSION=3 readout -> all outputs return to reset values at once.
- POINT_L1_NORM_EN, DIMENSION=3: load -3, 4, -5 -> l1_norm=12 and l1_valid=1 one cycle after pt_valid; a new load clears both.
